// File: rtl/cve2_instr_mem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : cve2_instr_mem_responder_pkg                                |
// | Brief  : Shared constants and address-decode helper for the          |
// |          instruction-memory responder.                               |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
package cve2_instr_mem_responder_pkg;

  localparam int unsigned c_WORD_W = 32;
  localparam int unsigned c_BE_W   = 4;

  // True when addr is word aligned and lies in [base, base+size). The
  // offset is compared on 33 bits so a window ending at 2^32 cannot wrap.
  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [32:0] size);
    logic [31:0] off;
    off = addr - base;
    return (addr >= base) && ({1'b0, off} < size) && (addr[1:0] == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cve2_instr_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : cve2_instr_ram                                              |
// | Brief  : Word-wide RAM, one synchronous read port and one            |
// |          byte-enabled write port. Read returns pre-write data.       |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module cve2_instr_ram
  import cve2_instr_mem_responder_pkg::*;
#(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned AddrWidth = $clog2(NumWords)
) (
  input  logic                 clk_i,
  input  logic                 re_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [c_WORD_W-1:0]  rdata_o,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [c_WORD_W-1:0]  wdata_i,
  input  logic [c_BE_W-1:0]    be_i
);

  logic [c_WORD_W-1:0] r_mem [NumWords];

  // Read and write share an edge; the non-blocking read sees the old word.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_o <= r_mem[raddr_i];
    end
    if (we_i) begin
      for (int b = 0; b < int'(c_BE_W); b++) begin
        if (be_i[b]) begin
          r_mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cve2_instr_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : cve2_instr_mem_responder                                    |
// | Brief  : Instruction-fetch memory model: grants core requests up to  |
// |          an outstanding limit and answers each after a fixed         |
// |          latency, in order, with data or a bus error.                |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module cve2_instr_mem_responder
  import cve2_instr_mem_responder_pkg::*;
#(
  parameter int unsigned NumWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h1000_0000,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                instr_req_i,
  input  logic [31:0]         instr_addr_i,
  output logic                instr_gnt_o,
  output logic                instr_rvalid_o,
  output logic [c_WORD_W-1:0] instr_rdata_o,
  output logic                instr_err_o,
  input  logic                stall_i,
  input  logic                load_we_i,
  input  logic [31:0]         load_addr_i,
  input  logic [c_WORD_W-1:0] load_wdata_i,
  input  logic [c_BE_W-1:0]   load_be_i,
  output logic                busy_o
);

  localparam int unsigned        c_AW    = $clog2(NumWords);
  localparam logic [32:0]        c_SIZE  = 33'(NumWords) << 2;
  localparam int unsigned        c_CNT_W = 3;
  localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(MaxOutstanding);

  typedef struct packed {
    logic                valid;
    logic                err;
    logic [c_WORD_W-1:0] data;
  } resp_t;

  logic [c_CNT_W-1:0]  r_outstanding;
  logic [c_CNT_W-1:0]  w_inflight;
  logic                w_req_ok;
  logic                w_load_ok;
  logic                w_gnt;
  logic [c_AW-1:0]     w_req_idx;
  logic [c_AW-1:0]     w_load_idx;
  logic [c_WORD_W-1:0] w_ram_rdata;
  logic                r_s0_valid;
  logic                r_s0_err;
  resp_t               w_s0;
  resp_t               w_out;

  assign w_req_ok   = addr_hit(instr_addr_i, BaseAddr, c_SIZE);
  assign w_load_ok  = addr_hit(load_addr_i, BaseAddr, c_SIZE);
  assign w_req_idx  = c_AW'((instr_addr_i - BaseAddr) >> 2);
  assign w_load_idx = c_AW'((load_addr_i - BaseAddr) >> 2);

  // A response leaving this cycle frees its slot for a same-cycle grant.
  assign w_inflight = r_outstanding - {{(c_CNT_W-1){1'b0}}, w_out.valid};
  assign w_gnt      = rst_ni & instr_req_i & ~stall_i & (w_inflight < c_MAX);

  // Outstanding count: +1 per grant, -1 per response, unchanged when both.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outstanding <= '0;
    end else if (w_gnt != w_out.valid) begin
      r_outstanding <= w_gnt ? r_outstanding + c_CNT_W'(1)
                             : r_outstanding - c_CNT_W'(1);
    end
  end

  // First response stage: records the grant and its error status; the word
  // itself arrives from the RAM read register in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s0_valid <= 1'b0;
      r_s0_err   <= 1'b0;
    end else begin
      r_s0_valid <= w_gnt;
      r_s0_err   <= w_gnt & ~w_req_ok;
    end
  end

  // Assemble stage 0, forcing data to zero for errors and empty slots.
  always_comb begin
    w_s0       = '0;
    w_s0.valid = r_s0_valid;
    w_s0.err   = r_s0_err;
    if (r_s0_valid && !r_s0_err) begin
      w_s0.data = w_ram_rdata;
    end
  end

  cve2_instr_ram #(
    .NumWords  (NumWords),
    .AddrWidth (c_AW)
  ) u_ram (
    .clk_i   (clk_i),
    .re_i    (w_gnt & w_req_ok),
    .raddr_i (w_req_idx),
    .rdata_o (w_ram_rdata),
    .we_i    (load_we_i & w_load_ok),
    .waddr_i (w_load_idx),
    .wdata_i (load_wdata_i),
    .be_i    (load_be_i)
  );

  if (Latency == 1) begin : g_lat1
    assign w_out = w_s0;
  end else begin : g_latn
    resp_t r_pipe [Latency-1];

    // Free-running delay line; there is no backpressure on responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_pipe <= '{default: '0};
      end else begin
        r_pipe[0] <= w_s0;
        for (int unsigned i = 1; i < Latency - 1; i++) begin
          r_pipe[i] <= r_pipe[i-1];
        end
      end
    end

    assign w_out = r_pipe[Latency-2];
  end

  assign instr_gnt_o    = w_gnt;
  assign instr_rvalid_o = w_out.valid;
  assign instr_err_o    = w_out.valid & w_out.err;
  assign instr_rdata_o  = w_out.valid ? w_out.data : '0;
  assign busy_o         = (r_outstanding != '0);

endmodule
`default_nettype wire

// File: tb/tb_cve2_instr_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_cve2_instr_mem_responder                                 |
// | Brief  : Directed, table-driven bench. Three responders share one    |
// |          stimulus bus, with latencies 1, 2 and 3.                     |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module tb_cve2_instr_mem_responder;

  localparam logic [31:0] B = 32'h1000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        stall_i;
  logic        load_we_i;
  logic [31:0] load_addr_i;
  logic [31:0] load_wdata_i;
  logic [3:0]  load_be_i;

  logic        gnt1, rv1, err1, busy1;
  logic [31:0] rd1;
  logic        gnt2, rv2, err2, busy2;
  logic [31:0] rd2;
  logic        gnt3, rv3, err3, busy3;
  logic [31:0] rd3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  cve2_instr_mem_responder #(.Latency(1), .MaxOutstanding(2)) dut_l1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(gnt1), .instr_rvalid_o(rv1), .instr_rdata_o(rd1), .instr_err_o(err1),
    .stall_i(stall_i), .load_we_i(load_we_i), .load_addr_i(load_addr_i),
    .load_wdata_i(load_wdata_i), .load_be_i(load_be_i), .busy_o(busy1));

  cve2_instr_mem_responder #(.Latency(2), .MaxOutstanding(2)) dut_l2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(gnt2), .instr_rvalid_o(rv2), .instr_rdata_o(rd2), .instr_err_o(err2),
    .stall_i(stall_i), .load_we_i(load_we_i), .load_addr_i(load_addr_i),
    .load_wdata_i(load_wdata_i), .load_be_i(load_be_i), .busy_o(busy2));

  cve2_instr_mem_responder #(.Latency(3), .MaxOutstanding(2)) dut_l3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(gnt3), .instr_rvalid_o(rv3), .instr_rdata_o(rd3), .instr_err_o(err3),
    .stall_i(stall_i), .load_we_i(load_we_i), .load_addr_i(load_addr_i),
    .load_wdata_i(load_wdata_i), .load_be_i(load_be_i), .busy_o(busy3));

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        stall;
    logic        lwe;
    logic [31:0] laddr;
    logic [31:0] lwd;
    logic [3:0]  lbe;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        err;
    logic        busy;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mkv(logic req, logic [31:0] addr, logic stall, logic lwe,
                               logic [31:0] laddr, logic [31:0] lwd, logic [3:0] lbe,
                               logic gnt, logic rv, logic [31:0] rd, logic err, logic busy);
    vec_t v;
    v.req = req; v.addr = addr; v.stall = stall; v.lwe = lwe; v.laddr = laddr;
    v.lwd = lwd; v.lbe = lbe; v.gnt = gnt; v.rv = rv; v.rd = rd; v.err = err; v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic nc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic drive(input logic req, input logic [31:0] addr, input logic stall);
    instr_req_i = req; instr_addr_i = addr; stall_i = stall;
    load_we_i = 1'b0; load_addr_i = '0; load_wdata_i = '0; load_be_i = '0;
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] data);
    drive(1'b0, B, 1'b0);
    load_we_i = 1'b1; load_addr_i = addr; load_wdata_i = data; load_be_i = 4'hF;
  endtask

  initial begin
    // Latency-1 vectors. Each row is one cycle: gnt reflects this row's
    // inputs, rvalid/rdata/err answer the previous row's grant.
    vecs[0]  = mkv(0, B,            0, 1, B,            32'h0000_0013, 4'hF, 0, 0, 32'h0,          0, 0);
    vecs[1]  = mkv(0, B,            0, 1, B + 32'h14,   32'h1122_3344, 4'hF, 0, 0, 32'h0,          0, 0);
    vecs[2]  = mkv(1, B,            0, 0, B,            32'h0,         4'h0, 1, 0, 32'h0,          0, 0);
    vecs[3]  = mkv(1, B + 32'h14,   0, 1, B + 32'h14,   32'hDEAD_BEEF, 4'hF, 1, 1, 32'h0000_0013,  0, 1);
    vecs[4]  = mkv(1, B + 32'h14,   0, 1, B + 32'h14,   32'h0000_00AA, 4'h1, 1, 1, 32'h1122_3344,  0, 1);
    vecs[5]  = mkv(1, B + 32'h14,   0, 0, B,            32'h0,         4'h0, 1, 1, 32'hDEAD_BEEF,  0, 1);
    vecs[6]  = mkv(1, 32'h0FFF_FFFC,0, 0, B,            32'h0,         4'h0, 1, 1, 32'hDEAD_BEAA,  0, 1);
    vecs[7]  = mkv(1, 32'h1000_1000,0, 0, B,            32'h0,         4'h0, 1, 1, 32'h0,          1, 1);
    vecs[8]  = mkv(1, 32'h1000_0002,0, 0, B,            32'h0,         4'h0, 1, 1, 32'h0,          1, 1);
    vecs[9]  = mkv(0, B,            0, 0, B,            32'h0,         4'h0, 0, 1, 32'h0,          1, 1);
    vecs[10] = mkv(0, B,            0, 0, B,            32'h0,         4'h0, 0, 0, 32'h0,          0, 0);
    vecs[11] = mkv(1, B,            1, 0, B,            32'h0,         4'h0, 0, 0, 32'h0,          0, 0);
    vecs[12] = mkv(0, B,            0, 1, 32'h1000_1000,32'hFFFF_FFFF, 4'hF, 0, 0, 32'h0,          0, 0);
    vecs[13] = mkv(0, B,            0, 1, 32'h1000_0015,32'h0,         4'hF, 0, 0, 32'h0,          0, 0);
    vecs[14] = mkv(1, B,            0, 0, B,            32'h0,         4'h0, 1, 0, 32'h0,          0, 0);
    vecs[15] = mkv(1, B + 32'h14,   0, 0, B,            32'h0,         4'h0, 1, 1, 32'h0000_0013,  0, 1);
    vecs[16] = mkv(0, B,            0, 0, B,            32'h0,         4'h0, 0, 1, 32'hDEAD_BEAA,  0, 1);
    vecs[17] = mkv(0, B,            0, 0, B,            32'h0,         4'h0, 0, 0, 32'h0,          0, 0);

    // Reset: requests are refused and every output is quiet.
    rst_ni = 1'b0;
    drive(1'b1, B, 1'b0);
    smp();
    chk("reset gnt l1", {31'b0, gnt1}, 32'd0);
    chk("reset gnt l3", {31'b0, gnt3}, 32'd0);
    chk("reset rvalid l1", {31'b0, rv1}, 32'd0);
    chk("reset rdata l1", rd1, 32'd0);
    chk("reset err/busy l1", {30'b0, err1, busy1}, 32'd0);
    nc();
    rst_ni = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].req, vecs[i].addr, vecs[i].stall);
      load_we_i = vecs[i].lwe; load_addr_i = vecs[i].laddr;
      load_wdata_i = vecs[i].lwd; load_be_i = vecs[i].lbe;
      smp();
      chk($sformatf("row%0d gnt", i),    {31'b0, gnt1},  {31'b0, vecs[i].gnt});
      chk($sformatf("row%0d rvalid", i), {31'b0, rv1},   {31'b0, vecs[i].rv});
      chk($sformatf("row%0d rdata", i),  rd1,            vecs[i].rd);
      chk($sformatf("row%0d err", i),    {31'b0, err1},  {31'b0, vecs[i].err});
      chk($sformatf("row%0d busy", i),   {31'b0, busy1}, {31'b0, vecs[i].busy});
      nc();
    end

    // Preload words 1 and 2, then let every instance drain.
    load(B + 32'h4, 32'h0000_00A1); smp(); nc();
    load(B + 32'h8, 32'h0000_00A2); smp(); nc();
    drive(1'b0, B, 1'b0);
    repeat (5) begin smp(); nc(); end

    // Latency 3, limit 2: third request waits until the first response
    // frees its slot in the same cycle; it then answers 3 cycles later.
    drive(1'b1, B, 1'b0);          smp(); chk("l3 c0 gnt", {31'b0, gnt3}, 32'd1); nc();
    drive(1'b1, B + 32'h4, 1'b0);  smp(); chk("l3 c1 gnt", {31'b0, gnt3}, 32'd1); nc();
    drive(1'b1, B + 32'h8, 1'b0);  smp(); chk("l3 c2 gnt", {31'b0, gnt3}, 32'd0);
    chk("l3 c2 rvalid", {31'b0, rv3}, 32'd0); nc();
    drive(1'b1, B + 32'h8, 1'b0);  smp(); chk("l3 c3 gnt", {31'b0, gnt3}, 32'd1);
    chk("l3 c3 rvalid", {31'b0, rv3}, 32'd1); chk("l3 c3 rdata", rd3, 32'h0000_0013);
    chk("l3 c3 busy", {31'b0, busy3}, 32'd1); nc();
    drive(1'b0, B, 1'b0);          smp(); chk("l3 c4 rvalid", {31'b0, rv3}, 32'd1);
    chk("l3 c4 rdata", rd3, 32'h0000_00A1); nc();
    smp(); chk("l3 c5 rvalid", {31'b0, rv3}, 32'd0); nc();
    smp(); chk("l3 c6 rvalid", {31'b0, rv3}, 32'd1);
    chk("l3 c6 rdata/err", {rd3[30:0], err3}, {31'h0000_00A2, 1'b0}); nc();
    smp(); chk("l3 c7 rvalid/busy", {30'b0, rv3, busy3}, 32'd0); nc();
    repeat (2) begin smp(); nc(); end

    // Latency 2: reset while two responses are in flight drops both.
    drive(1'b1, B + 32'h4, 1'b0); smp(); chk("l2 pre gnt0", {31'b0, gnt2}, 32'd1); nc();
    drive(1'b1, B + 32'h8, 1'b0); smp(); chk("l2 pre gnt1", {31'b0, gnt2}, 32'd1); nc();
    rst_ni = 1'b0;
    drive(1'b1, B, 1'b0);
    smp();
    chk("l2 in-reset rvalid", {31'b0, rv2}, 32'd0);
    chk("l2 in-reset gnt/busy", {30'b0, gnt2, busy2}, 32'd0);
    nc();
    rst_ni = 1'b1;
    drive(1'b0, B, 1'b0);
    for (int k = 0; k < 2; k++) begin
      smp();
      chk($sformatf("l2 post-reset%0d rvalid", k), {31'b0, rv2}, 32'd0);
      chk($sformatf("l2 post-reset%0d busy", k), {31'b0, busy2}, 32'd0);
      nc();
    end
    drive(1'b1, B, 1'b0);         smp(); chk("l2 new gnt0", {31'b0, gnt2}, 32'd1); nc();
    drive(1'b1, B + 32'h4, 1'b0); smp(); chk("l2 new gnt1", {31'b0, gnt2}, 32'd1);
    chk("l2 new busy", {31'b0, busy2}, 32'd1); nc();
    drive(1'b0, B, 1'b0);         smp(); chk("l2 new rdata0", {rd2[30:0], rv2}, {31'h0000_0013, 1'b1}); nc();
    smp(); chk("l2 new rdata1", {rd2[30:0], rv2}, {31'h0000_00A1, 1'b1}); nc();
    smp(); chk("l2 drained", {30'b0, rv2, busy2}, 32'd0); nc();
    repeat (2) begin smp(); nc(); end

    // Latency 3: stall holds gnt low but the in-flight response still lands.
    drive(1'b1, B + 32'h8, 1'b0); smp(); chk("stall c0 gnt", {31'b0, gnt3}, 32'd1); nc();
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, B, 1'b1);
      smp();
      chk($sformatf("stall c%0d gnt", k), {31'b0, gnt3}, 32'd0);
      chk($sformatf("stall c%0d rvalid", k), {31'b0, rv3}, (k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("stall c%0d rdata", k), rd3, (k == 3) ? 32'h0000_00A2 : 32'd0);
      nc();
    end
    drive(1'b0, B, 1'b0);
    smp();
    chk("stall end busy", {31'b0, busy3}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
